// File: rtl/scb_pkg.sv
// Shared types for the in-order commit scoreboard: FSM states, result codes and queued entry layout.
package scb_pkg;

    localparam int unsigned SCB_DATA_W = 32;
    localparam int unsigned SCB_RD_W   = 5;
    localparam int unsigned SCB_ERR_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HALT   = 2'd2
    } scb_state_t;

    typedef enum logic [SCB_ERR_W-1:0] {
        ERR_NONE          = 3'd0,
        ERR_PC_MISMATCH   = 3'd1,
        ERR_RD_MISMATCH   = 3'd2,
        ERR_DATA_MISMATCH = 3'd3,
        ERR_UNEXPECTED    = 3'd4,
        ERR_TIMEOUT       = 3'd5
    } scb_err_t;

    typedef struct packed {
        logic [SCB_DATA_W-1:0] pc;
        logic                  we;
        logic [SCB_RD_W-1:0]   rd;
        logic [SCB_DATA_W-1:0] data;
    } scb_entry_t;

endpackage

// File: rtl/scb_fifo.sv
// Synchronous FIFO of expected commit entries; push is refused when full, pop when empty.
module scb_fifo
    import scb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  scb_entry_t             wr_entry,
    output scb_entry_t             head_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    scb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == OCC_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rptr];
    assign do_push = push && !full_c && !flush;
    assign do_pop  = pop && !empty_c && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wr_entry;
    end

endmodule

// File: rtl/commit_scoreboard.sv
// In-order commit scoreboard: queues predicted write-backs and checks them against CPU commits.
// Optional head-entry watchdog enabled by defining SCB_TIMEOUT_EN.
module commit_scoreboard
    import scb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [DATA_W-1:0]      exp_pc,
    input  logic                   exp_we,
    input  logic [4:0]             exp_rd,
    input  logic [DATA_W-1:0]      exp_data,
    input  logic                   act_valid,
    input  logic [DATA_W-1:0]      act_pc,
    input  logic                   act_we,
    input  logic [4:0]             act_rd,
    input  logic [DATA_W-1:0]      act_data,
    output logic                   chk_done,
    output logic                   chk_pass,
    output logic [2:0]             err_code,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    scb_state_t       state_q, state_nxt;
    scb_err_t         err_q, err_nxt, res_err;
    logic             done_nxt, pass_nxt;
    logic [CNT_W-1:0] pass_cnt_nxt, fail_cnt_nxt;
    logic [OCC_W-1:0] occ_nxt;

    scb_entry_t wr_entry, head_c;
    logic       full_c, empty_c;
    logic       halted, push_c, commit_c, pop_c, wd_fire_c;

    assign halted    = (state_q == HALT);
    assign exp_ready = !full_c && !halted;
    assign push_c    = exp_valid && exp_ready && !flush;
    assign commit_c  = act_valid && !halted && !flush;
    assign pop_c     = (commit_c && !empty_c) || wd_fire_c;
    assign wr_entry  = '{pc: SCB_DATA_W'(exp_pc), we: exp_we, rd: exp_rd,
                         data: SCB_DATA_W'(exp_data)};

    scb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push_c),
        .pop      (pop_c),
        .wr_entry (wr_entry),
        .head_c   (head_c),
        .full_c   (full_c),
        .empty_c  (empty_c),
        .count    (count)
    );

`ifdef SCB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counts ACTIVE cycles without a commit; fires on the cycle the count would reach TIMEOUT.
    assign wd_fire_c = (state_q == ACTIVE) && !act_valid && !flush && !empty_c &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (flush || state_q != ACTIVE || act_valid || wd_fire_c)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    // Watchdog compiled out; TIMEOUT stays in the parameter list so both builds share one interface.
    assign wd_fire_c = 1'b0 && (TIMEOUT != 0);
`endif

    // Head compare with fixed priority: PC, then WE/RD, then data (only for real register writes).
    always_comb begin
        res_err = ERR_NONE;
        if (wd_fire_c)
            res_err = ERR_TIMEOUT;
        else if (empty_c)
            res_err = ERR_UNEXPECTED;
        else if (head_c.pc != SCB_DATA_W'(act_pc))
            res_err = ERR_PC_MISMATCH;
        else if (head_c.we != act_we || head_c.rd != act_rd)
            res_err = ERR_RD_MISMATCH;
        else if (head_c.we && head_c.rd != '0 && head_c.data != SCB_DATA_W'(act_data))
            res_err = ERR_DATA_MISMATCH;
    end

    always_comb begin
        done_nxt     = commit_c || wd_fire_c;
        pass_nxt     = done_nxt && (res_err == ERR_NONE);
        err_nxt      = done_nxt ? res_err : err_q;
        pass_cnt_nxt = pass_cnt;
        fail_cnt_nxt = fail_cnt;
        occ_nxt      = count + OCC_W'(push_c) - OCC_W'(pop_c);
        state_nxt    = state_q;

        if (pass_nxt && pass_cnt != '1)
            pass_cnt_nxt = pass_cnt + CNT_W'(1);
        if (done_nxt && !pass_nxt && fail_cnt != '1)
            fail_cnt_nxt = fail_cnt + CNT_W'(1);

        if (flush)
            state_nxt = IDLE;
        else if (state_q != HALT) begin
            if (done_nxt && !pass_nxt && STOP_ON_FAIL != 0)
                state_nxt = HALT;
            else if (occ_nxt == '0)
                state_nxt = IDLE;
            else
                state_nxt = ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            err_q    <= ERR_NONE;
            chk_done <= 1'b0;
            chk_pass <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            err_q    <= err_nxt;
            chk_done <= done_nxt;
            chk_pass <= pass_nxt;
            pass_cnt <= pass_cnt_nxt;
            fail_cnt <= fail_cnt_nxt;
        end
    end

    assign state    = state_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed bench for commit_scoreboard; a second instance with STOP_ON_FAIL=1 covers HALT.
module tb_commit_scoreboard;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        exp_valid, exp_we, act_valid, act_we;
    logic [4:0]  exp_rd, act_rd;
    logic [31:0] exp_pc, exp_data, act_pc, act_data;

    logic        exp_ready, chk_done, chk_pass;
    logic [2:0]  err_code;
    logic [15:0] pass_cnt, fail_cnt;
    logic [1:0]  state;
    logic [3:0]  count;

    logic        h_exp_ready, h_chk_done, h_chk_pass;
    logic [2:0]  h_err_code;
    logic [15:0] h_pass_cnt, h_fail_cnt;
    logic [1:0]  h_state;
    logic [3:0]  h_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    commit_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc), .exp_we(exp_we),
        .exp_rd(exp_rd), .exp_data(exp_data),
        .act_valid(act_valid), .act_pc(act_pc), .act_we(act_we), .act_rd(act_rd),
        .act_data(act_data),
        .chk_done(chk_done), .chk_pass(chk_pass), .err_code(err_code),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .state(state), .count(count)
    );

    commit_scoreboard #(.DEPTH(DEPTH), .STOP_ON_FAIL(1)) dut_h (
        .clk(clk), .reset(reset), .flush(flush),
        .exp_valid(exp_valid), .exp_ready(h_exp_ready), .exp_pc(exp_pc), .exp_we(exp_we),
        .exp_rd(exp_rd), .exp_data(exp_data),
        .act_valid(act_valid), .act_pc(act_pc), .act_we(act_we), .act_rd(act_rd),
        .act_data(act_data),
        .chk_done(h_chk_done), .chk_pass(h_chk_pass), .err_code(h_err_code),
        .pass_cnt(h_pass_cnt), .fail_cnt(h_fail_cnt), .state(h_state), .count(h_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                        input logic [31:0] d);
        exp_valid = 1'b1; exp_pc = pc; exp_we = we; exp_rd = rd; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                          input logic [31:0] d);
        act_valid = 1'b1; act_pc = pc; act_we = we; act_rd = rd; act_data = d;
        tick();
        act_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic pass, input logic [2:0] err);
        chk({tag, "_done"}, 32'(chk_done), 32'd1);
        chk({tag, "_pass"}, 32'(chk_pass), 32'(pass));
        chk({tag, "_err"},  32'(err_code), 32'(err));
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        exp_valid = 1'b0; exp_we = 1'b0; exp_rd = '0; exp_pc = '0; exp_data = '0;
        act_valid = 1'b0; act_we = 1'b0; act_rd = '0; act_pc = '0; act_data = '0;
        repeat (2) tick();

        chk("rst_ready", 32'(exp_ready), 32'd1);
        chk("rst_done",  32'(chk_done),  32'd0);
        chk("rst_pass",  32'(chk_pass),  32'd0);
        chk("rst_err",   32'(err_code),  32'd0);
        chk("rst_pcnt",  32'(pass_cnt),  32'd0);
        chk("rst_fcnt",  32'(fail_cnt),  32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_state", 32'(state),     32'd0);
        reset = 1'b1;
        tick();

        // Three matching transactions.
        push(32'h0, 1'b1, 5'd3, 32'h10);
        push(32'h4, 1'b1, 5'd3, 32'h20);
        push(32'h8, 1'b1, 5'd3, 32'h30);
        chk("push3_count", 32'(count), 32'd3);
        chk("push3_state", 32'(state), 32'd1);
        commit(32'h0, 1'b1, 5'd3, 32'h10);
        check_result("c0", 1'b1, 3'd0);
        commit(32'h4, 1'b1, 5'd3, 32'h20);
        check_result("c1", 1'b1, 3'd0);
        commit(32'h8, 1'b1, 5'd3, 32'h30);
        check_result("c2", 1'b1, 3'd0);
        chk("c_pcnt",  32'(pass_cnt), 32'd3);
        chk("c_state", 32'(state),    32'd0);
        tick();
        chk("done_one_cycle", 32'(chk_done), 32'd0);

        // Data mismatch, then PC mismatch; STOP_ON_FAIL instance halts on the first.
        push(32'h4, 1'b1, 5'd3, 32'h21);
        commit(32'h4, 1'b1, 5'd3, 32'h20);
        check_result("data_mm", 1'b0, 3'd3);
        chk("data_mm_fcnt", 32'(fail_cnt),    32'd1);
        chk("h_state_halt", 32'(h_state),     32'd2);
        chk("h_ready_halt", 32'(h_exp_ready), 32'd0);
        push(32'h4, 1'b1, 5'd3, 32'h1);
        commit(32'h8, 1'b1, 5'd3, 32'h1);
        check_result("pc_mm", 1'b0, 3'd1);
        chk("pc_mm_fcnt", 32'(fail_cnt),   32'd2);
        chk("h_ign_act",  32'(h_fail_cnt), 32'd1);

        // Flush with a coincident push: queue empties, halted instance recovers.
        push(32'h40, 1'b1, 5'd1, 32'h1);
        flush = 1'b1; exp_valid = 1'b1;
        tick();
        flush = 1'b0; exp_valid = 1'b0;
        chk("flush_count",   32'(count),   32'd0);
        chk("flush_state",   32'(state),   32'd0);
        chk("h_flush_state", 32'(h_state), 32'd0);
        chk("flush_fcnt",    32'(fail_cnt), 32'd2);

        // RD mismatch takes priority over data; rd=0 ignores data.
        push(32'h10, 1'b1, 5'd5, 32'h7);
        commit(32'h10, 1'b1, 5'd6, 32'h8);
        check_result("rd_mm", 1'b0, 3'd2);
        push(32'h20, 1'b1, 5'd0, 32'h1);
        commit(32'h20, 1'b1, 5'd0, 32'h2);
        check_result("rd0_pass", 1'b1, 3'd0);

        // Commit with empty queue; push and commit together onto empty queue.
        commit(32'h0, 1'b0, 5'd0, 32'h0);
        check_result("unexp", 1'b0, 3'd4);
        chk("unexp_count", 32'(count), 32'd0);
        exp_valid = 1'b1; exp_pc = 32'h30; exp_we = 1'b1; exp_rd = 5'd2; exp_data = 32'h9;
        act_valid = 1'b1; act_pc = 32'h30; act_we = 1'b1; act_rd = 5'd2; act_data = 32'h9;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        check_result("unexp_push", 1'b0, 3'd4);
        chk("unexp_push_count", 32'(count), 32'd1);
        commit(32'h30, 1'b1, 5'd2, 32'h9);
        check_result("drain_one", 1'b1, 3'd0);
        chk("mid_fcnt", 32'(fail_cnt), 32'd5);
        chk("mid_pcnt", 32'(pass_cnt), 32'd5);

        // Fill, refused push, push+pop while full, then wrap over 3*DEPTH transfers.
        for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 1'b1, 5'd1, 32'(i));
        chk("full_ready", 32'(exp_ready), 32'd0);
        chk("full_count", 32'(count),     32'd8);
        push(32'h100, 1'b1, 5'd1, 32'h100);
        chk("full_drop_count", 32'(count), 32'd8);
        exp_valid = 1'b1; exp_pc = 32'h100; exp_data = 32'h100;
        commit(32'h0, 1'b1, 5'd1, 32'h0);
        exp_valid = 1'b0;
        check_result("full_pop", 1'b1, 3'd0);
        chk("full_pop_count", 32'(count),     32'd7);
        chk("full_pop_ready", 32'(exp_ready), 32'd1);
        for (int k = 8; k < 32; k++) begin
            exp_valid = 1'b1; exp_pc = 32'(k * 4); exp_we = 1'b1; exp_rd = 5'd1; exp_data = 32'(k);
            commit(32'((k - 7) * 4), 1'b1, 5'd1, 32'(k - 7));
            exp_valid = 1'b0;
            chk("wrap_pass",  32'(chk_pass), 32'd1);
            chk("wrap_count", 32'(count),    32'd7);
        end
        for (int k = 25; k < 32; k++) begin
            commit(32'(k * 4), 1'b1, 5'd1, 32'(k));
            chk("drain_pass", 32'(chk_pass), 32'd1);
        end
        chk("wrap_end_count", 32'(count),    32'd0);
        chk("wrap_end_state", 32'(state),    32'd0);
        chk("wrap_end_pcnt",  32'(pass_cnt), 32'd37);

        // Head entry with no commit.
        push(32'h200, 1'b1, 5'd7, 32'h55);
        repeat (63) tick();
        chk("wd_wait_count", 32'(count),    32'd1);
        chk("wd_wait_done",  32'(chk_done), 32'd0);
`ifdef SCB_TIMEOUT_EN
        tick();
        check_result("timeout", 1'b0, 3'd5);
        chk("timeout_count", 32'(count),    32'd0);
        chk("timeout_fcnt",  32'(fail_cnt), 32'd6);
`else
        repeat (10) tick();
        chk("nowd_count", 32'(count), 32'd1);
        commit(32'h200, 1'b1, 5'd7, 32'h55);
        check_result("nowd_commit", 1'b1, 3'd0);
        chk("nowd_pcnt", 32'(pass_cnt), 32'd38);
`endif

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++) push(32'(i * 4), 1'b1, 5'd1, 32'(i));
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_pcnt",  32'(pass_cnt),  32'd0);
        chk("arst_fcnt",  32'(fail_cnt),  32'd0);
        chk("arst_state", 32'(state),     32'd0);
        chk("arst_ready", 32'(exp_ready), 32'd1);
        chk("arst_err",   32'(err_code),  32'd0);
        #1 reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/commit_scoreboard.md
# commit_scoreboard

In-order commit scoreboard for the MIPS verification environment. It queues expected write-back results produced by the checker model, compares them against the CPU's architectural commit stream, and reports one-cycle pass/fail strobes with an error code and saturating pass/fail counters. It generalises the single-operation OpDone check into a parametrised, depth-buffered, latency-tolerant comparator that sits between the predictor and the top-level test report.

## Interface
Parameters:
- DATA_W, 32, width of PC and result data
- DEPTH, 8, expected-entry queue depth (power of two, ≥2)
- CNT_W, 16, width of pass/fail counters
- TIMEOUT, 64, cycles without a commit before head entry is declared lost
- STOP_ON_FAIL, 0, 1 = enter HALT after first failure

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear; counters kept
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  queue can accept (= !full)
- exp_pc  in  DATA_W  PC of predicted instruction
- exp_we  in  1  instruction writes a register
- exp_rd  in  5  destination register
- exp_data  in  DATA_W  predicted write-back value
- act_valid  in  1  CPU commit strobe
- act_pc, act_we, act_rd, act_data  in  DATA_W/1/5/DATA_W  committed instruction fields
- chk_done  out  1  one-cycle result strobe
- chk_pass  out  1  qualifies chk_done
- err_code  out  3  scb_err_t code of last result
- pass_cnt, fail_cnt  out  CNT_W  saturating counters
- state  out  2  current scb_state_t
- count  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Push: exp_valid && exp_ready writes {pc,we,rd,data} at tail. No push when full, even if a pop occurs the same cycle.
- Commit: act_valid with non-empty queue pops head and compares. Error priority: PC_MISMATCH(1) > WE/RD mismatch RD_MISMATCH(2) > DATA_MISMATCH(3). Data compared only if exp_we=1 and exp_rd≠0. All equal → pass, err_code NONE(0).
- act_valid with empty queue → fail, UNEXPECTED(4), no pop.
- States: IDLE (empty) → ACTIVE on push; ACTIVE → IDLE when last entry pops with no push; any fail with STOP_ON_FAIL=1 → HALT. HALT ignores act_valid, exp_ready=0, leaves only via flush or reset.
- flush: empties queue, clears timeout counter, state → IDLE; a push or commit coincident with flush is discarded.
- Counters saturate at all-ones; cleared only by reset.

## Timing
- Commit accepted at cycle N → chk_done/chk_pass/err_code valid at N+1 (registered); chk_done high exactly one cycle.
- exp_ready combinational from registered occupancy; push visible in count at N+1.
- Simultaneous push and pop when non-full: occupancy unchanged; push onto empty queue plus act_valid same cycle → UNEXPECTED (entry not yet at head).
- Pointers wrap modulo DEPTH; full = count==DEPTH.
- Reset values: exp_ready=1, chk_done=0, chk_pass=0, err_code=0, counters=0, count=0, state=IDLE, queue pointers 0.
- Reset asserted mid-operation discards all entries immediately.

## Configuration
- SCB_TIMEOUT_EN defined: watchdog counter increments each ACTIVE cycle without act_valid; reaching TIMEOUT produces fail, TIMEOUT(5), pops head, clears counter. Coincident act_valid takes precedence and clears counter.
- Undefined: no watchdog logic; code 5 never emitted; entries wait indefinitely.

## Structure
- scb_pkg: scb_state_t {IDLE, ACTIVE, HALT}, scb_err_t {NONE, PC_MISMATCH, RD_MISMATCH, DATA_MISMATCH, UNEXPECTED, TIMEOUT}, scb_entry_t packed struct {pc, we, rd, data}. Imported alongside AluCtrlSig_pkg.
- Sub-module scb_fifo: parametrised synchronous FIFO of scb_entry_t with push/pop/flush, full/empty/count; compare, FSM, counters, watchdog stay in commit_scoreboard.

## Test plan
- Push 3 entries (pc 0x0,0x4,0x8, rd 3, data 0x10/0x20/0x30), matching commits → 3 chk_pass strobes one cycle after each commit, pass_cnt=3, state IDLE.
- Commit pc 0x4 data 0x20 against head data 0x21 → chk_done, chk_pass=0, err_code=3, fail_cnt=1; PC 0x8 vs 0x4 → err_code=1.
- Fill DEPTH entries → exp_ready=0, extra push dropped; one commit → exp_ready=1 next cycle; pointer wrap verified over 3×DEPTH transfers.
- act_valid on empty queue → err_code=4, count stays 0; exp_rd=0 with differing data → pass.
- SCB_TIMEOUT_EN, TIMEOUT=64: one entry, no commit 64 cycles → err_code=5, count=0; STOP_ON_FAIL=1 → state HALT until flush.
- Reset pulsed low with 5 entries queued → count=0, counters 0, all outputs at reset values asynchronously.
